// File: rtl/encap_tx_scheduler.sv
// Packet-level round-robin scheduler for the shared UDP/IP encapsulation path.
// Grants one requester, forwards its length/ID, then muxes its payload stream until tlast.
module encap_tx_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned ID_WIDTH  = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned KEEP_W    = DATA_WIDTH / 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*16-1:0]           i_req_len,
    output logic [N_REQ-1:0]              o_req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_s_payload_tdata,
    input  logic [N_REQ*KEEP_W-1:0]       i_s_payload_tkeep,
    input  logic [N_REQ-1:0]              i_s_payload_tvalid,
    input  logic [N_REQ-1:0]              i_s_payload_tlast,
    output logic [N_REQ-1:0]              o_s_payload_tready,
    output logic [15:0]                   o_m_len,
    output logic [ID_WIDTH-1:0]           o_m_src_id,
    output logic                          o_m_len_valid,
    input  logic                          i_m_len_ready,
    output logic [DATA_WIDTH-1:0]         o_m_payload_tdata,
    output logic [KEEP_W-1:0]             o_m_payload_tkeep,
    output logic                          o_m_payload_tvalid,
    output logic                          o_m_payload_tlast,
    input  logic                          i_m_payload_tready,
    output logic [N_REQ-1:0]              o_grant,
    output logic                          o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_WIDTH-1:0] r_last_grant;

    logic                w_any_req;
    logic [ID_WIDTH-1:0] w_winner;
    logic                w_len_active;
    logic                w_pay_active;
    logic                w_src_tvalid;
    logic                w_src_tlast;
    logic                w_last_beat;

    // Rotating priority: scan from last_grant+1 downward in distance so the nearest valid wins
    always_comb begin
        w_winner = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            if (i_req_valid[(int'(r_last_grant) + k) % int'(N_REQ)]) begin
                w_winner = ID_WIDTH'((int'(r_last_grant) + k) % int'(N_REQ));
            end
        end
    end

    assign w_any_req    = |i_req_valid;
    // Reset gates the combinational paths so nothing is forwarded in the reset cycle
    assign w_len_active = (r_state == ST_LEN) && !i_rst;
    assign w_pay_active = (r_state == ST_PAYLOAD) && !i_rst;
    assign w_src_tvalid = i_s_payload_tvalid[o_m_src_id];
    assign w_src_tlast  = i_s_payload_tlast[o_m_src_id];
    assign w_last_beat  = w_pay_active && w_src_tvalid && i_m_payload_tready && w_src_tlast;

    assign o_req_ready        = w_len_active ? (o_grant & {N_REQ{i_m_len_ready}}) : '0;
    assign o_s_payload_tready = w_pay_active ? (o_grant & {N_REQ{i_m_payload_tready}}) : '0;
    assign o_m_payload_tvalid = w_pay_active && w_src_tvalid;
    assign o_m_payload_tlast  = w_pay_active && w_src_tlast;
    assign o_m_payload_tdata  = w_pay_active
                              ? i_s_payload_tdata[32'(o_m_src_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_m_payload_tkeep  = w_pay_active
                              ? i_s_payload_tkeep[32'(o_m_src_id)*KEEP_W +: KEEP_W] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= ID_WIDTH'(N_REQ - 1);
            o_m_len       <= '0;
            o_m_src_id    <= '0;
            o_m_len_valid <= 1'b0;
            o_grant       <= '0;
            o_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state       <= ST_LEN;
                        r_last_grant  <= w_winner;
                        o_m_src_id    <= w_winner;
                        o_m_len       <= i_req_len[32'(w_winner)*16 +: 16];
                        o_grant       <= N_REQ'(1) << w_winner;
                        o_m_len_valid <= 1'b1;
                        o_busy        <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (i_m_len_ready) begin
                        o_m_len_valid <= 1'b0;
                        if (o_m_len == 16'd0) begin
                            r_state <= ST_IDLE;
                            o_grant <= '0;
                            o_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_last_beat) begin
                        r_state <= ST_IDLE;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    o_grant       <= '0;
                    o_m_len_valid <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encap_tx_scheduler.sv
// Bench for encap_tx_scheduler: behavioural reference compared every cycle plus directed literal checks.
module tb_encap_tx_scheduler;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid   = '0;
    logic [N*16-1:0] req_len     = '0;
    logic [N*DW-1:0] s_tdata     = '0;
    logic [N*KW-1:0] s_tkeep     = '0;
    logic [N-1:0]    s_tvalid    = '0;
    logic [N-1:0]    s_tlast     = '0;
    logic            m_len_ready = 1'b0;
    logic            m_tready    = 1'b0;

    logic [N-1:0]    req_ready;
    logic [N-1:0]    s_tready;
    logic [15:0]     m_len;
    logic [IW-1:0]   m_src_id;
    logic            m_len_valid;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic [N-1:0]    grant;
    logic            busy;

    encap_tx_scheduler #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (req_valid),
        .i_req_len          (req_len),
        .o_req_ready        (req_ready),
        .i_s_payload_tdata  (s_tdata),
        .i_s_payload_tkeep  (s_tkeep),
        .i_s_payload_tvalid (s_tvalid),
        .i_s_payload_tlast  (s_tlast),
        .o_s_payload_tready (s_tready),
        .o_m_len            (m_len),
        .o_m_src_id         (m_src_id),
        .o_m_len_valid      (m_len_valid),
        .i_m_len_ready      (m_len_ready),
        .o_m_payload_tdata  (m_tdata),
        .o_m_payload_tkeep  (m_tkeep),
        .o_m_payload_tvalid (m_tvalid),
        .o_m_payload_tlast  (m_tlast),
        .i_m_payload_tready (m_tready),
        .o_grant            (grant),
        .o_busy             (busy)
    );

    int cmp_total = 0;
    int cmp_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_total++;
        if (act !== exp) begin
            cmp_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: phase 0 = idle, 1 = length offered, 2 = payload streaming
    int ph = 0, src = 0, mlen = 0, last = N - 1;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; src = 0; mlen = 0; last = N - 1; model_ok = 1'b1;
        end else if (model_ok) begin
            if (ph == 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (last + k) % N;
                    if (req_valid[idx]) begin
                        src = idx; mlen = int'(req_len[idx*16 +: 16]); last = idx; ph = 1;
                        break;
                    end
                end
            end else if (ph == 1) begin
                if (m_len_ready) ph = (mlen == 0) ? 0 : 2;
            end else begin
                if (s_tvalid[src] && m_tready && s_tlast[src]) ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        bit la, pa;
        if (model_ok) begin
            eg = (ph != 0) ? (N'(1) << src) : '0;
            la = (ph == 1) && !rst;
            pa = (ph == 2) && !rst;
            chk("busy",        busy,        ph != 0);
            chk("m_len_valid", m_len_valid, ph == 1);
            chk("grant",       grant,       eg);
            chk("m_len",       m_len,       64'(mlen));
            chk("m_src_id",    m_src_id,    64'(src));
            chk("req_ready",   req_ready,   (la && m_len_ready) ? eg : '0);
            chk("s_tready",    s_tready,    (pa && m_tready) ? eg : '0);
            chk("m_tvalid",    m_tvalid,    pa ? s_tvalid[src] : 1'b0);
            chk("m_tlast",     m_tlast,     pa ? s_tlast[src] : 1'b0);
            chk("m_tdata",     m_tdata,     pa ? s_tdata[src*DW +: DW] : '0);
            chk("m_tkeep",     m_tkeep,     pa ? s_tkeep[src*KW +: KW] : '0);
        end
    end

    int          cyc_n = 0;
    int          hs_id[$];
    int          hs_cyc[$];
    logic [63:0] fwd[$];
    bit          s1_seen = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (m_len_valid && m_len_ready) begin
            hs_id.push_back(int'(m_src_id));
            hs_cyc.push_back(cyc_n);
        end
        if (m_tvalid && m_tready) fwd.push_back(m_tdata);
        if (s_tready[1]) s1_seen = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; s_tvalid = '0; s_tlast = '0;
        m_len_ready = 1'b0; m_tready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_ids[6];
        logic [63:0] bd[4];
        bit          tr[4];
        bit          tl[4];
        exp_ids = '{0, 1, 2, 3, 0, 1};

        // Reset values
        cyc(); cyc(); mid();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_len_valid", m_len_valid, 1'b0);
        chk("rst_m_len", m_len, 16'd0);
        chk("rst_src", m_src_id, 2'd0);

        // Single requester, two beats
        do_reset();
        req_valid = 4'b0100; req_len[32 +: 16] = 16'd16; m_len_ready = 1'b1; m_tready = 1'b1;
        fwd.delete();
        mid(); chk("t1_idle_busy", busy, 1'b0);
        cyc();
        s_tvalid[2] = 1'b1; s_tdata[128 +: 64] = 64'h1111_2222_3333_4444;
        s_tkeep[16 +: 8] = 8'hFF; s_tlast[2] = 1'b0;
        mid();
        chk("t1_len_valid", m_len_valid, 1'b1);
        chk("t1_src", m_src_id, 2'd2);
        chk("t1_grant", grant, 4'b0100);
        chk("t1_len", m_len, 16'd16);
        chk("t1_req_ready", req_ready, 4'b0100);
        cyc(); req_valid = '0;
        mid();
        chk("t1_b0_valid", m_tvalid, 1'b1);
        chk("t1_b0_data", m_tdata, 64'h1111_2222_3333_4444);
        chk("t1_s_tready", s_tready, 4'b0100);
        cyc(); s_tdata[128 +: 64] = 64'h5555_6666_7777_8888; s_tlast[2] = 1'b1;
        mid();
        chk("t1_b1_data", m_tdata, 64'h5555_6666_7777_8888);
        chk("t1_b1_last", m_tlast, 1'b1);
        chk("t1_b1_keep", m_tkeep, 8'hFF);
        cyc(); s_tvalid = '0; s_tlast = '0;
        mid();
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_grant_drop", grant, 4'b0000);
        chk("t1_fwd_count", fwd.size(), 2);

        // All requesters valid, one-beat packets
        do_reset();
        hs_id.delete(); hs_cyc.delete();
        req_valid = 4'b1111; req_len = {16'd8, 16'd8, 16'd8, 16'd8};
        s_tvalid = 4'b1111; s_tlast = 4'b1111; s_tkeep = '1;
        for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = 64'hA000 + 64'(i);
        m_len_ready = 1'b1; m_tready = 1'b1;
        repeat (20) cyc();
        req_valid = '0;
        repeat (4) cyc();
        s_tvalid = '0; s_tlast = '0;
        chk("t2_count", hs_id.size() >= 6, 1'b1);
        if (hs_id.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t2_order%0d", i), 64'(hs_id[i]), 64'(exp_ids[i]));
            for (int i = 0; i < 5; i++) chk($sformatf("t2_gap%0d", i), 64'(hs_cyc[i+1] - hs_cyc[i]), 3);
        end

        // Zero length
        do_reset();
        s1_seen = 1'b0;
        req_valid = 4'b0010; req_len[16 +: 16] = 16'd0; m_len_ready = 1'b1; m_tready = 1'b1;
        s_tvalid[1] = 1'b1;
        cyc();
        mid();
        chk("t3_len_valid", m_len_valid, 1'b1);
        chk("t3_len", m_len, 16'd0);
        chk("t3_src", m_src_id, 2'd1);
        cyc(); req_valid = '0;
        mid();
        chk("t3_idle_busy", busy, 1'b0);
        cyc(); mid();
        chk("t3_tready1_seen", s1_seen, 1'b0);
        s_tvalid = '0;

        // Backpressure on length then payload
        do_reset();
        req_valid = 4'b1000; req_len[48 +: 16] = 16'd24;
        cyc();
        for (int i = 0; i < 5; i++) begin
            req_len[48 +: 16] = 16'h00F0 + 16'(i);
            mid();
            chk("t4_hold_len", m_len, 16'd24);
            chk("t4_hold_src", m_src_id, 2'd3);
            chk("t4_hold_grant", grant, 4'b1000);
            chk("t4_hold_rdy", req_ready, 4'b0000);
            cyc();
        end
        m_len_ready = 1'b1;
        mid(); chk("t4_req_ready", req_ready, 4'b1000);
        cyc(); req_valid = '0; fwd.delete();
        bd = '{64'hB0, 64'hB1, 64'hB1, 64'hB2};
        tr = '{1'b1, 1'b0, 1'b1, 1'b1};
        tl = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            s_tdata[192 +: 64] = bd[i]; s_tvalid[3] = 1'b1; s_tlast[3] = tl[i]; m_tready = tr[i];
            mid();
            chk("t4_beat", m_tdata, bd[i]);
            cyc();
        end
        s_tvalid = '0; s_tlast = '0;
        mid();
        chk("t4_done", busy, 1'b0);
        chk("t4_fwd_count", fwd.size(), 3);
        if (fwd.size() == 3) begin
            chk("t4_fwd0", fwd[0], 64'hB0);
            chk("t4_fwd1", fwd[1], 64'hB1);
            chk("t4_fwd2", fwd[2], 64'hB2);
        end

        // Isolation of non-granted source
        do_reset();
        req_valid = 4'b0001; req_len[0 +: 16] = 16'd8; m_len_ready = 1'b1; m_tready = 1'b1;
        s_tvalid[3] = 1'b1; s_tdata[192 +: 64] = 64'hDEAD;
        cyc();
        s_tdata[0 +: 64] = 64'hCAFE; s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1;
        cyc(); req_valid = '0;
        mid();
        chk("t5_tready", s_tready, 4'b0001);
        chk("t5_data", m_tdata, 64'hCAFE);
        cyc(); s_tvalid = '0; s_tlast = '0;

        // Reset in the middle of a payload
        do_reset();
        req_valid = 4'b0010; req_len[16 +: 16] = 16'd32; m_len_ready = 1'b1; m_tready = 1'b1;
        cyc();
        s_tvalid[1] = 1'b1; s_tdata[64 +: 64] = 64'hC0; s_tlast[1] = 1'b0;
        cyc(); req_valid = '0;
        mid(); chk("t6_b0", m_tdata, 64'hC0);
        cyc(); s_tdata[64 +: 64] = 64'hC1; rst = 1'b1;
        mid();
        chk("t6_rst_tvalid", m_tvalid, 1'b0);
        chk("t6_rst_tready", s_tready, 4'b0000);
        cyc(); rst = 1'b0; s_tvalid = '0; req_valid = 4'b1111;
        mid();
        chk("t6_busy", busy, 1'b0);
        chk("t6_grant", grant, 4'b0000);
        chk("t6_len_valid", m_len_valid, 1'b0);
        chk("t6_len", m_len, 16'd0);
        chk("t6_src", m_src_id, 2'd0);
        chk("t6_tvalid", m_tvalid, 1'b0);
        cyc();
        mid();
        chk("t6_first_src", m_src_id, 2'd0);
        chk("t6_first_grant", grant, 4'b0001);
        req_valid = '0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
        $finish;
    end

endmodule
